// File: rtl/mmio_store_ctrl_pkg.sv
// Shared IO map for the MMIO window (0x8000_0000..0x8000_0020) and the TX FSM encoding.
// The IO read mux imports the same package so both sides agree on addresses.
package mmio_store_ctrl_pkg;

  localparam logic [31:0] IO_UART_CTRL_ADDR = 32'h8000_0000;
  localparam logic [31:0] IO_RX_ADDR        = 32'h8000_0004;
  localparam logic [31:0] IO_TX_ADDR        = 32'h8000_0008;
  localparam logic [31:0] IO_CYC_ADDR       = 32'h8000_0010;
  localparam logic [31:0] IO_INSTR_ADDR     = 32'h8000_0014;
  localparam logic [31:0] IO_CRST_ADDR      = 32'h8000_0018;
  localparam logic [31:0] IO_BR_ADDR        = 32'h8000_001C;
  localparam logic [31:0] IO_BR_CORRECT_ADDR = 32'h8000_0020;

  typedef enum logic {
    TxIdle = 1'b0,
    TxSend = 1'b1
  } tx_state_e;

  function automatic logic is_io_addr(input logic [31:0] addr);
    return addr[31:30] == 2'b10;
  endfunction

endpackage

// File: rtl/mmio_store_ctrl_perf_counter.sv
// Free-running performance counter with synchronous clear; clear wins over increment.
module mmio_store_ctrl_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mmio_store_ctrl.sv
// Store side of the MMIO window: UART TX valid/ready handshake, RX read ack, perf counters.
// Define BR_COUNTERS_EN to add the retired-branch and correct-branch counters.
module mmio_store_ctrl
  import mmio_store_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] TX_ADDR   = IO_TX_ADDR,
  parameter logic [31:0] RX_ADDR   = IO_RX_ADDR,
  parameter logic [31:0] CRST_ADDR = IO_CRST_ADDR
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_st_en,
  input  logic             i_ld_en,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_wdata,
  input  logic             i_instr_retire,
  input  logic             i_br_retire,
  input  logic             i_br_correct,
  input  logic             i_uart_tx_ready,
  output logic [7:0]       o_uart_tx_data_in,
  output logic             o_uart_tx_data_in_valid,
  output logic             o_uart_rx_data_out_ready,
  output logic             o_io_stall,
  output logic [CNT_W-1:0] o_cyc_counter,
  output logic [CNT_W-1:0] o_instr_counter,
  output logic [CNT_W-1:0] o_br_instr_counter,
  output logic [CNT_W-1:0] o_correct_br_counter
);

  tx_state_e  r_state, w_state_d;
  logic [7:0] r_tx_data, w_tx_data_d;
  logic       w_io_hit, w_tx_st, w_cnt_clr;
  logic       w_unused_wdata;

  assign w_io_hit  = is_io_addr(i_addr);
  assign w_tx_st   = i_st_en && w_io_hit && (i_addr == TX_ADDR);
  assign w_cnt_clr = i_st_en && w_io_hit && (i_addr == CRST_ADDR);

  // Only the low byte of a TX store is transmitted.
  assign w_unused_wdata = ^i_wdata[31:8];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= TxIdle;
      r_tx_data <= 8'h00;
    end else begin
      r_state   <= w_state_d;
      r_tx_data <= w_tx_data_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_tx_data_d = r_tx_data;
    case (r_state)
      TxIdle: begin
        if (w_tx_st) begin
          w_state_d   = TxSend;
          w_tx_data_d = i_wdata[7:0];
        end
      end
      TxSend: begin
        if (i_uart_tx_ready) begin
          w_state_d = TxIdle;
        end
      end
      default: w_state_d = TxIdle;
    endcase
  end

  assign o_uart_tx_data_in        = r_tx_data;
  assign o_uart_tx_data_in_valid  = (r_state == TxSend);
  // Stall covers the fire cycle too: a new byte is only taken once back in idle.
  assign o_io_stall               = w_tx_st && (r_state == TxSend);
  assign o_uart_rx_data_out_ready = i_ld_en && w_io_hit && (i_addr == RX_ADDR);

  mmio_store_ctrl_perf_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_cnt_clr),
    .i_inc   (1'b1),
    .o_count (o_cyc_counter)
  );

  mmio_store_ctrl_perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_cnt_clr),
    .i_inc   (i_instr_retire),
    .o_count (o_instr_counter)
  );

`ifdef BR_COUNTERS_EN
  mmio_store_ctrl_perf_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_cnt_clr),
    .i_inc   (i_br_retire),
    .o_count (o_br_instr_counter)
  );

  mmio_store_ctrl_perf_counter #(.CNT_W(CNT_W)) u_br_correct_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_cnt_clr),
    .i_inc   (i_br_retire && i_br_correct),
    .o_count (o_correct_br_counter)
  );
`else
  logic w_unused_br;
  assign w_unused_br          = i_br_retire ^ i_br_correct;
  assign o_br_instr_counter   = '0;
  assign o_correct_br_counter = '0;
`endif

  // Stage 3 never issues a load and a store in the same cycle.
  assert property (@(posedge i_clk) disable iff (i_rst) !(i_st_en && i_ld_en));

endmodule

// File: tb/tb_mmio_store_ctrl.sv
// Directed bench for mmio_store_ctrl; TX bytes are checked against a queue of accepted stores.
// A second instance with 4-bit counters exercises counter wrap-around.
module tb_mmio_store_ctrl;

  localparam logic [31:0] A_UART_CTRL = 32'h8000_0000;
  localparam logic [31:0] A_RX        = 32'h8000_0004;
  localparam logic [31:0] A_TX        = 32'h8000_0008;
  localparam logic [31:0] A_CRST      = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_en, ld_en, instr_retire, br_retire, br_correct, tx_ready;
  logic [31:0] addr, wdata;
  logic [7:0]  tx_data;
  logic        tx_valid, rx_ready, stall;
  logic [31:0] cyc, instr, br_cnt, br_ok_cnt;
  logic [7:0]  tx_data_s;
  logic        tx_valid_s, rx_ready_s, stall_s;
  logic [3:0]  cyc_s, instr_s, br_cnt_s, br_ok_cnt_s;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;
  logic [31:0] exp_br, exp_br_ok;

  always #5 clk = ~clk;

  mmio_store_ctrl u_dut (
    .i_clk                    (clk),
    .i_rst                    (rst),
    .i_st_en                  (st_en),
    .i_ld_en                  (ld_en),
    .i_addr                   (addr),
    .i_wdata                  (wdata),
    .i_instr_retire           (instr_retire),
    .i_br_retire              (br_retire),
    .i_br_correct             (br_correct),
    .i_uart_tx_ready          (tx_ready),
    .o_uart_tx_data_in        (tx_data),
    .o_uart_tx_data_in_valid  (tx_valid),
    .o_uart_rx_data_out_ready (rx_ready),
    .o_io_stall               (stall),
    .o_cyc_counter            (cyc),
    .o_instr_counter          (instr),
    .o_br_instr_counter       (br_cnt),
    .o_correct_br_counter     (br_ok_cnt)
  );

  mmio_store_ctrl #(.CNT_W(4)) u_dut_w4 (
    .i_clk                    (clk),
    .i_rst                    (rst),
    .i_st_en                  (st_en),
    .i_ld_en                  (ld_en),
    .i_addr                   (addr),
    .i_wdata                  (wdata),
    .i_instr_retire           (instr_retire),
    .i_br_retire              (br_retire),
    .i_br_correct             (br_correct),
    .i_uart_tx_ready          (tx_ready),
    .o_uart_tx_data_in        (tx_data_s),
    .o_uart_tx_data_in_valid  (tx_valid_s),
    .o_uart_rx_data_out_ready (rx_ready_s),
    .o_io_stall               (stall_s),
    .o_cyc_counter            (cyc_s),
    .o_instr_counter          (instr_s),
    .o_br_instr_counter       (br_cnt_s),
    .o_correct_br_counter     (br_ok_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    st_en        = 1'b0;
    ld_en        = 1'b0;
    addr         = 32'h0;
    wdata        = 32'h0;
    instr_retire = 1'b0;
    br_retire    = 1'b0;
    br_correct   = 1'b0;
  endtask

  // A byte leaves the DUT at the posedge after a negedge where valid and ready are both high.
  always @(negedge clk) begin
    #2;
    if (!rst && tx_valid && tx_ready) begin
      check("tx_fire_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_b});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef BR_COUNTERS_EN
    exp_br    = 32'd5;
    exp_br_ok = 32'd3;
`else
    exp_br    = 32'd0;
    exp_br_ok = 32'd0;
`endif
    rst      = 1'b1;
    tx_ready = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_cyc", cyc, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_br", br_cnt, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    // Reset while a byte is pending with ready low: byte dropped, counters cleared.
    @(negedge clk);
    rst = 1'b0;
    st_en = 1'b1; addr = A_TX; wdata = 32'h0000_0055; instr_retire = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    check("t1_valid_pre", 32'(tx_valid), 32'd1);
    check("t1_instr_pre", instr, 32'd1);
    rst = 1'b1;
    #1;
    check("t1_valid_rst", 32'(tx_valid), 32'd0);
    check("t1_cyc_rst", cyc, 32'd0);
    check("t1_instr_rst", instr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single byte with three cycles of backpressure.
    @(negedge clk);
    st_en = 1'b1; addr = A_TX; wdata = 32'h1234_5641;
    exp_q.push_back(8'h41);
    #1;
    check("t2_stall_idle", 32'(stall), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      tx_ready = (i == 3);
      #1;
      check("t2_valid", 32'(tx_valid), 32'd1);
      check("t2_data", {24'd0, tx_data}, 32'h41);
    end
    @(negedge clk);
    tx_ready = 1'b0;
    #1;
    check("t2_valid_drop", 32'(tx_valid), 32'd0);

    // Second store during SEND stalls until idle, then both bytes go out in order.
    @(negedge clk);
    st_en = 1'b1; addr = A_TX; wdata = 32'h61;
    exp_q.push_back(8'h61);
    #1;
    check("t3_stall_a", 32'(stall), 32'd0);
    @(negedge clk);
    wdata = 32'h62;
    #1;
    check("t3_stall_1", 32'(stall), 32'd1);
    check("t3_data_a", {24'd0, tx_data}, 32'h61);
    @(negedge clk);
    #1;
    check("t3_stall_2", 32'(stall), 32'd1);
    @(negedge clk);
    tx_ready = 1'b1;
    #1;
    check("t3_stall_fire", 32'(stall), 32'd1);
    @(negedge clk);
    tx_ready = 1'b0;
    exp_q.push_back(8'h62);
    #1;
    check("t3_stall_idle", 32'(stall), 32'd0);
    check("t3_valid_idle", 32'(tx_valid), 32'd0);
    @(negedge clk);
    idle_inputs();
    tx_ready = 1'b1;
    #1;
    check("t3_valid_b", 32'(tx_valid), 32'd1);
    check("t3_data_b", {24'd0, tx_data}, 32'h62);
    @(negedge clk);
    tx_ready = 1'b0;
    #1;
    check("t3_valid_end", 32'(tx_valid), 32'd0);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // RX acknowledge is a per-load combinational pulse; loads elsewhere have no effect.
    @(negedge clk);
    ld_en = 1'b1; addr = A_RX;
    #1;
    check("t4_rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t4_rx_ready_off", 32'(rx_ready), 32'd0);
    @(negedge clk);
    ld_en = 1'b1; addr = A_UART_CTRL;
    #1;
    check("t4_rx_other", 32'(rx_ready), 32'd0);
    @(negedge clk);
    ld_en = 1'b1; addr = A_TX;
    #1;
    check("t4_ld_tx_stall", 32'(stall), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t4_ld_tx_valid", 32'(tx_valid), 32'd0);

    // Clear beats a same-cycle increment; then count and wrap on the 4-bit instance.
    @(negedge clk);
    st_en = 1'b1; addr = A_CRST; wdata = 32'hDEAD_BEEF; instr_retire = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    check("t5_instr_clr", instr, 32'd0);
    check("t5_cyc_clr", cyc, 32'd0);
    check("t5_cyc_s_clr", {28'd0, cyc_s}, 32'd0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      instr_retire = (k <= 3);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("t5_cyc_15", cyc, 32'd15);
    check("t5_cyc_s_max", {28'd0, cyc_s}, 32'd15);
    check("t5_instr_3", instr, 32'd3);
    @(negedge clk);
    #1;
    check("t5_cyc_16", cyc, 32'd16);
    check("t5_cyc_s_wrap", {28'd0, cyc_s}, 32'd0);

    // Branch counters: 5 retired branches, 3 predicted correctly.
    @(negedge clk);
    st_en = 1'b1; addr = A_CRST;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle_inputs();
      br_retire  = 1'b1;
      br_correct = (k == 0) || (k == 2) || (k == 3);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("t6_br", br_cnt, exp_br);
    check("t6_br_ok", br_ok_cnt, exp_br_ok);
    @(negedge clk);
    st_en = 1'b1; addr = A_CRST; br_retire = 1'b1; br_correct = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    check("t6_br_clr", br_cnt, 32'd0);
    check("t6_br_ok_clr", br_ok_cnt, 32'd0);

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
